// File: rtl/tt_sel_driver.sv
`default_nettype none
// ============================================================================
// Module   : tt_sel_driver
// Purpose  : Initiator for the design-select control interface. On an
//            accepted request it holds the controller's select counter in
//            reset, emits exactly req_addr increment pulses and then enables
//            the selected design.
// Ports    : clk, rst (sync, active high)
//            req_valid / req_ready / req_addr : selection request port
//            busy, done                       : sequence status
//            cur_addr, cur_valid              : last completed selection
//            ctrl_sel_rst_n, ctrl_sel_inc,
//            ctrl_ena                         : control-high pad drivers
// Revision : 1.0 - initial release
// ============================================================================
module tt_sel_driver #(
  parameter int ADDR_W  = 10,
  parameter int RST_CYC = 8,
  parameter int PULSE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int c_max_cyc = (RST_CYC > PULSE_W) ? RST_CYC : PULSE_W;
  localparam int c_tmr_w   = $clog2(c_max_cyc) + 1;

  localparam logic [c_tmr_w-1:0] c_rst_load   = c_tmr_w'(RST_CYC - 1);
  localparam logic [c_tmr_w-1:0] c_pulse_load = c_tmr_w'(PULSE_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_GAP    = 3'd2,
    ST_INC_HI = 3'd3,
    ST_INC_LO = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  state_t              r_state, w_state_nx;
  logic [c_tmr_w-1:0]  r_timer, w_timer_nx;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nx;     // increments still to emit
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;   // address of the running request
  logic [ADDR_W-1:0]   w_cur_addr_nx;
  logic                w_cur_valid_nx;
  logic [ADDR_W-1:0]   w_cnt_dec;
  logic                w_timer_zero;

  logic w_sel_rst_n_nx, w_inc_nx, w_ena_nx, w_done_nx, w_busy_nx;

  assign req_ready    = (r_state == ST_IDLE);
  assign w_cnt_dec    = r_cnt - ADDR_W'(1);
  assign w_timer_zero = (r_timer == '0);

  always_comb begin
    w_state_nx     = r_state;
    w_timer_nx     = r_timer;
    w_cnt_nx       = r_cnt;
    w_addr_nx      = r_addr;
    w_cur_addr_nx  = cur_addr;
    w_cur_valid_nx = cur_valid;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_cnt_nx       = req_addr;
          w_addr_nx      = req_addr;
          w_timer_nx     = c_rst_load;
          w_state_nx     = ST_RST;
          w_cur_valid_nx = 1'b0;
        end
      end
      ST_RST: begin
        if (w_timer_zero) begin
          w_timer_nx = c_pulse_load;
          w_state_nx = ST_GAP;
        end else begin
          w_timer_nx = r_timer - c_tmr_w'(1);
        end
      end
      ST_GAP: begin
        if (w_timer_zero) begin
          w_timer_nx = c_pulse_load;
          w_state_nx = (r_cnt != '0) ? ST_INC_HI : ST_FIN;
        end else begin
          w_timer_nx = r_timer - c_tmr_w'(1);
        end
      end
      ST_INC_HI: begin
        if (w_timer_zero) begin
          w_timer_nx = c_pulse_load;
          w_state_nx = ST_INC_LO;
        end else begin
          w_timer_nx = r_timer - c_tmr_w'(1);
        end
      end
      ST_INC_LO: begin
        if (w_timer_zero) begin
          w_timer_nx = c_pulse_load;
          w_cnt_nx   = w_cnt_dec;
          w_state_nx = (w_cnt_dec != '0) ? ST_INC_HI : ST_FIN;
        end else begin
          w_timer_nx = r_timer - c_tmr_w'(1);
        end
      end
      ST_FIN: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    // Selection result becomes visible in the same cycle as done.
    if (w_state_nx == ST_FIN) begin
      w_cur_addr_nx  = r_addr;
      w_cur_valid_nx = 1'b1;
    end

    // Pad and status outputs are decoded from the next state so that the
    // registered copies line up exactly with the state they describe.
    w_inc_nx  = (w_state_nx == ST_INC_HI);
    w_done_nx = (w_state_nx == ST_FIN);
    w_busy_nx = (w_state_nx != ST_IDLE);
    if (w_state_nx == ST_IDLE) begin
      // Hold the last selection active while idle; nothing selected after reset.
      w_sel_rst_n_nx = w_cur_valid_nx;
      w_ena_nx       = w_cur_valid_nx;
    end else begin
      w_sel_rst_n_nx = (w_state_nx != ST_RST);
      w_ena_nx       = (w_state_nx == ST_FIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_cnt          <= '0;
      r_addr         <= '0;
      cur_addr       <= '0;
      cur_valid      <= 1'b0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_timer        <= w_timer_nx;
      r_cnt          <= w_cnt_nx;
      r_addr         <= w_addr_nx;
      cur_addr       <= w_cur_addr_nx;
      cur_valid      <= w_cur_valid_nx;
      ctrl_sel_rst_n <= w_sel_rst_n_nx;
      ctrl_sel_inc   <= w_inc_nx;
      ctrl_ena       <= w_ena_nx;
      busy           <= w_busy_nx;
      done           <= w_done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_sel_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_sel_driver
// Purpose  : Self-checking bench for tt_sel_driver. Expected waveforms are
//            computed from the cycle-position rules of the select sequence;
//            a model of the controller's select counter checks the number of
//            increments seen at every completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_sel_driver;

  localparam int ADDR_W  = 10;
  localparam int RST_CYC = 8;
  localparam int PULSE_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_ready, busy, done, cur_valid;
  logic [ADDR_W-1:0] cur_addr;
  logic              ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;

  tt_sel_driver #(.ADDR_W(ADDR_W), .RST_CYC(RST_CYC), .PULSE_W(PULSE_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .busy(busy), .done(done), .cur_addr(cur_addr), .cur_valid(cur_valid),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_ena(ctrl_ena)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   inc_edges = 0;   // inc rising edges since the test last cleared it
  int   model_ctr = 0;   // controller select-counter model
  logic prev_inc = 1'b0;

  typedef struct {
    int addr;
    int exp_l;
    int exp_edges;
  } vec_t;
  vec_t tbl[5];

  // Controller-side observer plus pad-level safety rules, sampled mid-cycle.
  always @(negedge clk) begin
    if (!ctrl_sel_rst_n) model_ctr = 0;
    else if (ctrl_sel_inc && !prev_inc) model_ctr++;
    if (ctrl_sel_inc && !prev_inc) inc_edges++;
    prev_inc = ctrl_sel_inc;
    checks++;
    if ((ctrl_sel_inc && !ctrl_sel_rst_n) || (ctrl_ena && busy && !done)) begin
      errors++;
      $display("FAIL pad_rules t=%0t inc=%b rst_n=%b ena=%b busy=%b done=%b (inc needs rst_n, ena only idle/fin)",
               $time, ctrl_sel_inc, ctrl_sel_rst_n, ctrl_ena, busy, done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Increment high in cycle k after accept for address a?
  function automatic logic exp_inc(input int a, input int k);
    int off;
    off = k - (RST_CYC + PULSE_W + 1);
    return (off >= 0) && (off < 2 * a * PULSE_W) && ((off % (2 * PULSE_W)) < PULSE_W);
  endfunction

  // Full cycle-by-cycle check of one request from accept to ready again.
  task automatic run_directed(input int a, input string nm, output int done_k, output int edges);
    int L;
    logic [6:0] got, exp;
    L = RST_CYC + PULSE_W + 2 * a * PULSE_W + 1;
    done_k = -1;
    inc_edges = 0;
    req_valid = 1'b1;
    req_addr  = ADDR_W'(a);
    step();
    req_valid = 1'b0;
    req_addr  = ADDR_W'($urandom);
    for (int k = 1; k <= L + 1; k++) begin
      exp = {k > RST_CYC, exp_inc(a, k), k >= L, k == L, k <= L, k == L + 1, k >= L};
      got = {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy, req_ready, cur_valid};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle=%0d {rst_n,inc,ena,done,busy,ready,cvalid} got=%b expected=%b",
                 nm, k, got, exp);
      end
      if (done && done_k < 0) done_k = k;
      if (k < L + 1) step();
    end
    chk({nm, "_cur_addr"}, int'(cur_addr), a);
    edges = inc_edges;
  endtask

  task automatic wait_done(input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (done) return;
      step();
    end
    errors++;
    $display("FAIL %s_timeout got=no done expected=done within %0d cycles", nm, budget);
  endtask

  initial begin
    int dk, ed, first_rdy, e5, a;

    tbl[0] = '{addr: 3,    exp_l: 37,   exp_edges: 3};
    tbl[1] = '{addr: 0,    exp_l: 13,   exp_edges: 0};
    tbl[2] = '{addr: 1,    exp_l: 21,   exp_edges: 1};
    tbl[3] = '{addr: 7,    exp_l: 69,   exp_edges: 7};
    tbl[4] = '{addr: 1023, exp_l: 8197, exp_edges: 1023};

    // Reset then idle: everything stays at reset values.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_outputs",
          int'({ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done, cur_valid, req_ready}),
          int'(7'b0000001));
      chk("idle_cur_addr", int'(cur_addr), 0);
    end

    // Table-driven complete selections.
    for (int i = 0; i < 5; i++) begin
      run_directed(tbl[i].addr, $sformatf("vec%0d", i), dk, ed);
      chk($sformatf("vec%0d_latency", i), dk, tbl[i].exp_l);
      chk($sformatf("vec%0d_edges", i), ed, tbl[i].exp_edges);
    end

    // Request held valid (with another address) while busy.
    inc_edges = 0;
    e5 = -1;
    first_rdy = -1;
    req_valid = 1'b1;
    req_addr  = 10'd5;
    step();
    req_addr = 10'd9;
    for (int k = 1; k <= 200; k++) begin
      if (done && e5 < 0) begin
        e5 = inc_edges;
        chk("busy_first_cur_addr", int'(cur_addr), 5);
      end
      if (req_ready) begin
        first_rdy = k;
        break;
      end
      step();
    end
    chk("busy_first_ready_cycle", first_rdy, 54);
    chk("busy_first_edges", e5, 5);
    inc_edges = 0;
    step();
    req_valid = 1'b0;
    wait_done(200, "busy_second");
    chk("busy_second_cur_addr", int'(cur_addr), 9);
    chk("busy_second_edges", inc_edges, 9);
    chk("busy_second_model", model_ctr, 9);
    step();

    // Reset during the second increment-high phase of address 4.
    req_valid = 1'b1;
    req_addr  = 10'd4;
    step();
    req_valid = 1'b0;
    for (int k = 1; k < 22; k++) step();
    chk("midrst_inc_before", int'(ctrl_sel_inc), 1);
    rst = 1'b1;
    step();
    chk("midrst_outputs",
        int'({ctrl_sel_inc, ctrl_ena, ctrl_sel_rst_n, cur_valid, req_ready, busy, done}),
        int'(7'b0000100));
    rst = 1'b0;
    step();

    // Reset and request together: reset wins.
    rst = 1'b1;
    req_valid = 1'b1;
    req_addr = 10'd7;
    step();
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_req_busy", int'(busy), 0);
    rst = 1'b0;
    req_valid = 1'b0;
    step();
    chk("rst_req_busy_after", int'(busy), 0);

    // Random addresses against the controller counter model.
    for (int i = 0; i < 50; i++) begin
      a = (i == 0) ? 0 : (i == 1) ? 1023 : int'($urandom_range(0, 63));
      req_valid = 1'b1;
      req_addr  = ADDR_W'(a);
      step();
      req_valid = 1'b0;
      req_addr  = ADDR_W'($urandom);
      wait_done(9000, "rand");
      chk($sformatf("rand%0d_model_ctr", i), model_ctr, a);
      chk($sformatf("rand%0d_cur_addr", i), int'(cur_addr), a);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_sel_driver.md
Name: tt_sel_driver

Overview:
- Initiator side of the design-select control interface: generates the `ctrl_sel_rst_n`, `ctrl_sel_inc` and `ctrl_ena` waveforms that the controller samples on its control-high pads.
- Takes a target user-module address through a valid/ready request port.
- Resets the controller's select counter, emits exactly `addr` increment pulses, then enables the selected design.
- Sits on the management/test side (Caravel logic or FPGA test harness) and drives the control-high pins.

Parameters:
- ADDR_W, 10, width of the design address (5-bit branch + 5-bit module index).
- RST_CYC, 8, cycles `ctrl_sel_rst_n` is held low per selection (≥1).
- PULSE_W, 4, cycles per `ctrl_sel_inc` high phase and per low phase (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  selection request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_W  target design address, sampled on accept.
- busy  out  1  high from the cycle after accept until the done cycle inclusive.
- done  out  1  one-cycle pulse when `ctrl_ena` rises.
- cur_addr  out  ADDR_W  last completed selection.
- cur_valid  out  1  `cur_addr` is valid (a selection has completed since reset).
- ctrl_sel_rst_n  out  1  controller select-counter reset, active low.
- ctrl_sel_inc  out  1  controller select-counter increment strobe.
- ctrl_ena  out  1  enable for the selected design.

Behaviour:
- All outputs come from flops; no combinational path from inputs to outputs except `req_ready` = (state==IDLE).
- Reset values: `ctrl_sel_rst_n`=0, `ctrl_sel_inc`=0, `ctrl_ena`=0, `busy`=0, `done`=0, `cur_valid`=0, `cur_addr`=0; state = IDLE.
- States:
  - IDLE: `ctrl_sel_rst_n` = `cur_valid`; `ctrl_ena` = `cur_valid`.
  - RST: timer = RST_CYC.
  - GAP: timer = PULSE_W.
  - INC_HI: timer = PULSE_W.
  - INC_LO: timer = PULSE_W.
  - FIN: one cycle.
- Accept at edge T0 when `req_valid & req_ready`:
  - latch `req_addr` into the increment counter;
  - go to RST;
  - `cur_valid` clears at T0.
- RST:
  - `ctrl_sel_rst_n`=0, `ctrl_ena`=0, `ctrl_sel_inc`=0 for exactly RST_CYC cycles (cycles 1..RST_CYC after T0);
  - then GAP.
- GAP:
  - `ctrl_sel_rst_n`=1, `ctrl_sel_inc`=0 for PULSE_W cycles;
  - then INC_HI if remaining count ≠0, else FIN.
- INC_HI: `ctrl_sel_inc`=1 for PULSE_W cycles, then INC_LO.
- INC_LO:
  - `ctrl_sel_inc`=0 for PULSE_W cycles;
  - decrement remaining count at the exit edge;
  - go to INC_HI if the decremented count ≠0, else FIN.
- FIN:
  - `ctrl_ena`=1, `done`=1 for one cycle;
  - `cur_addr`=latched addr, `cur_valid`=1;
  - next state IDLE (`ctrl_ena` stays 1).
- `ctrl_ena` first high at cycle L = RST_CYC + PULSE_W + 2·addr·PULSE_W + 1 after T0.
- `req_ready` returns high at L+1.
- Exactly `addr` rising edges on `ctrl_sel_inc` per request. Address 0 gives no inc pulses.
- `ctrl_sel_inc` never high while `ctrl_sel_rst_n`=0; `ctrl_ena` never high while not in IDLE/FIN.
- Requests while busy are ignored (`req_ready`=0); `req_addr` changes after accept have no effect.
- A request for the address already selected still runs the full sequence; `ctrl_ena` drops during it.
- Counter widths: timer ≥ clog2(max(RST_CYC,PULSE_W))+1; increment counter ADDR_W bits; no wrap. Address 2^ADDR_W−1 must complete correctly.
- `rst` mid-sequence: next edge forces reset values. `ctrl_sel_rst_n` low, `ctrl_ena` low, any partial inc pulse truncated, `cur_valid`=0.
- `rst` and `req_valid` together: reset wins, request not accepted.

Test Plan:
- Reset, then idle 20 cycles → all outputs at reset values, `req_ready`=1, `ctrl_sel_rst_n`=0.
- Defaults, request addr=3 → `ctrl_sel_rst_n` low cycles 1–8 after T0, inc high cycles 13–16, 21–24, 29–32 (3 rising edges), `ctrl_ena`+`done` at cycle 37, `cur_addr`=3, `req_ready` at 38.
- Request addr=0 → no inc edges, `ctrl_ena`/`done` at cycle 13, `cur_addr`=0, `cur_valid`=1.
- Request addr=5, hold `req_valid` with addr=9 throughout busy → second request accepted only at L+1; first selection yields exactly 5 inc edges.
- Assert `rst` during the 2nd inc-high phase of addr=4 → next cycle `ctrl_sel_inc`=0, `ctrl_ena`=0, `ctrl_sel_rst_n`=0, `cur_valid`=0, `req_ready`=1.
- Bench model of the controller's select counter (reset on `ctrl_sel_rst_n` low, count `ctrl_sel_inc` rising edges), 50 random addresses incl. 0 and 1023 → model count == `cur_addr` at every `done`.
